// File: rtl/msx_audio_mixer.sv
// rtl/msx_audio_mixer.sv - N-channel time-multiplexed audio mixer with shared MAC, saturate/wrap and clip LED
module msx_audio_mixer #(
    parameter int NCH       = 4,
    parameter int IW        = 16,
    parameter int VOLW      = 4,
    parameter int OW        = 16,
    parameter int CLIP_HOLD = 1000000
) (
    input  logic                 clk_sys,
    input  logic                 reset,
    input  logic                 ce_sample,
    input  logic [NCH*IW-1:0]    ch_in,
    input  logic [NCH*VOLW-1:0]  ch_vol,
    input  logic [NCH-1:0]       ch_mute,
    input  logic                 sat_mode,
    output logic [OW-1:0]        audio_out,
    output logic                 out_valid,
    output logic                 busy,
    output logic                 clip,
    output logic                 clip_led,
    output logic                 overrun
);

    localparam int PW = IW + VOLW + 1;
    localparam int AW = PW + $clog2(NCH);
    localparam int XW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int CW = $clog2(CLIP_HOLD + 1);

    localparam logic signed [AW-1:0] MAXV = {{(AW-OW+1){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [AW-1:0] MINV = {{(AW-OW+1){1'b1}}, {(OW-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_ACC, S_OUT} state_t;

    state_t                state;
    state_t                state_nx;
    logic [IW-1:0]         snap_in  [NCH];
    logic [VOLW-1:0]       snap_vol [NCH];
    logic [NCH-1:0]        snap_mute;
    logic [XW-1:0]         idx;
    logic signed [AW-1:0]  acc;
    logic signed [PW-1:0]  prod;
    logic signed [AW-1:0]  result;
    logic                  over;
    logic                  under;
    logic [CW-1:0]         clip_cnt;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (ce_sample) state_nx = S_ACC;
            S_ACC:   if (idx == XW'(NCH - 1)) state_nx = S_OUT;
            S_OUT:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state != S_IDLE);
    end

    // Volume is unsigned, so a zero sign bit is prepended before the signed multiply.
    always_comb begin
        prod = '0;
        if (!snap_mute[idx]) begin
            prod = PW'($signed(snap_in[idx])) * PW'($signed({1'b0, snap_vol[idx]}));
        end
    end

    always_comb begin
        result = acc >>> (VOLW - 1);
        over   = (result > MAXV);
        under  = (result < MINV);
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NCH; k++) begin
                snap_in[k]  <= '0;
                snap_vol[k] <= '0;
            end
            snap_mute <= '0;
            acc       <= '0;
            idx       <= '0;
            audio_out <= '0;
            out_valid <= 1'b0;
            clip      <= 1'b0;
            overrun   <= 1'b0;
            clip_cnt  <= '0;
        end else begin
            out_valid <= 1'b0;
            clip      <= 1'b0;
            overrun   <= ce_sample && (state != S_IDLE);
            case (state)
                S_IDLE: begin
                    if (ce_sample) begin
                        for (int k = 0; k < NCH; k++) begin
                            snap_in[k]  <= ch_in[k*IW +: IW];
                            snap_vol[k] <= ch_vol[k*VOLW +: VOLW];
                        end
                        snap_mute <= ch_mute;
                        acc       <= '0;
                        idx       <= '0;
                    end
                end
                S_ACC: begin
                    acc <= acc + AW'(prod);
                    idx <= idx + XW'(1);
                end
                S_OUT: begin
                    out_valid <= 1'b1;
                    clip      <= over || under;
                    if (sat_mode || !(over || under)) begin
                        audio_out <= result[OW-1:0];
                    end else if (over) begin
                        audio_out <= MAXV[OW-1:0];
                    end else begin
                        audio_out <= MINV[OW-1:0];
                    end
                end
                default: ;
            endcase

            // A fresh clip reloads the hold counter even while it is still running.
            if (state == S_OUT && (over || under)) begin
                clip_cnt <= CW'(CLIP_HOLD);
            end else if (clip_cnt != '0) begin
                clip_cnt <= clip_cnt - CW'(1);
            end
        end
    end

    always_comb begin
        clip_led = (clip_cnt != '0);
    end

endmodule

// File: tb/tb_msx_audio_mixer.sv
// tb/tb_msx_audio_mixer.sv - scoreboard bench for msx_audio_mixer with directed and random mixes
module tb_msx_audio_mixer;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        ce_sample;
    logic [63:0] ch_in;
    logic [15:0] ch_vol;
    logic [3:0]  ch_mute;
    logic        sat_mode;
    logic [15:0] audio_out;
    logic        out_valid;
    logic        busy;
    logic        clip;
    logic        clip_led;
    logic        overrun;

    int checks   = 0;
    int failures = 0;

    logic [16:0] sb[$];
    int          cin[4];
    int          cvol[4];
    logic [3:0]  cm;
    logic        csat;

    msx_audio_mixer #(
        .NCH(4), .IW(16), .VOLW(4), .OW(16), .CLIP_HOLD(16)
    ) dut (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .ce_sample (ce_sample),
        .ch_in     (ch_in),
        .ch_vol    (ch_vol),
        .ch_mute   (ch_mute),
        .sat_mode  (sat_mode),
        .audio_out (audio_out),
        .out_valid (out_valid),
        .busy      (busy),
        .clip      (clip),
        .clip_led  (clip_led),
        .overrun   (overrun)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_ch(input int a0, input int a1, input int a2, input int a3,
                          input int v0, input int v1, input int v2, input int v3,
                          input logic [3:0] m, input logic s);
        cin[0] = a0; cin[1] = a1; cin[2] = a2; cin[3] = a3;
        cvol[0] = v0; cvol[1] = v1; cvol[2] = v2; cvol[3] = v3;
        cm = m;
        csat = s;
        for (int k = 0; k < 4; k++) begin
            ch_in[k*16 +: 16] = 16'(cin[k]);
            ch_vol[k*4 +: 4]  = 4'(cvol[k]);
        end
        ch_mute  = cm;
        sat_mode = csat;
    endtask

    function automatic logic [16:0] model();
        longint      acc = 0;
        longint      r;
        logic        c;
        logic [15:0] a;
        for (int k = 0; k < 4; k++)
            if (!cm[k]) acc += longint'(cin[k]) * longint'(cvol[k]);
        r = acc >>> 3;
        c = (r > 32767) || (r < -32768);
        if (!csat && r > 32767)       a = 16'h7FFF;
        else if (!csat && r < -32768) a = 16'h8000;
        else                          a = r[15:0];
        return {c, a};
    endfunction

    task automatic strobe();
        ce_sample = 1'b1;
        tick();
        ce_sample = 1'b0;
    endtask

    task automatic collect(input string tag, input int exp_lat);
        int          n = 0;
        logic [16:0] e;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_seen"}, 32'(out_valid), 32'd1);
        chk({tag, "_lat"}, 32'(n), 32'(exp_lat));
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_audio"}, 32'(audio_out), 32'(e[15:0]));
            chk({tag, "_clip"}, 32'(clip), 32'(e[16]));
        end
    endtask

    task automatic run_mix(input string tag, input logic [15:0] ea, input logic ec);
        sb.push_back({ec, ea});
        strobe();
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        collect(tag, 5);
    endtask

    task automatic count_valid(input string tag, input int cycles, input int exp);
        int n = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (out_valid) n++;
        end
        chk(tag, 32'(n), 32'(exp));
    endtask

    initial begin
        int n;
        reset     = 1'b1;
        ce_sample = 1'b0;
        set_ch(0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 1'b0);
        tick();
        tick();
        chk("rst_audio", 32'(audio_out), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_clip", 32'(clip), 32'd0);
        chk("rst_led", 32'(clip_led), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        reset = 1'b0;
        tick();

        set_ch(1000, 0, 0, 0, 8, 8, 8, 8, 4'b0000, 1'b0);
        run_mix("unity", 16'd1000, 1'b0);
        chk("unity_led", 32'(clip_led), 32'd0);

        set_ch(800, 0, 0, 0, 15, 8, 8, 8, 4'b0000, 1'b0);
        run_mix("gain15", 16'd1500, 1'b0);

        set_ch(-3, 5000, 5000, 5000, 1, 8, 8, 8, 4'b1110, 1'b0);
        run_mix("floor", 16'hFFFF, 1'b0);

        set_ch(-3, 0, 0, 0, 0, 8, 8, 8, 4'b0000, 1'b0);
        run_mix("vol0", 16'h0000, 1'b0);

        set_ch(16'h7000, 16'h7000, 16'h7000, 16'h7000, 8, 8, 8, 8, 4'b0000, 1'b0);
        run_mix("sat_pos", 16'h7FFF, 1'b1);
        n = 0;
        while (clip_led && n < 100) begin
            n++;
            tick();
        end
        chk("clip_led_len", 32'(n), 32'd16);

        set_ch(-28672, -28672, -28672, -28672, 8, 8, 8, 8, 4'b0000, 1'b0);
        run_mix("sat_neg", 16'h8000, 1'b1);

        set_ch(16'h7000, 16'h7000, 16'h7000, 16'h7000, 8, 8, 8, 8, 4'b0000, 1'b1);
        run_mix("wrap", 16'hC000, 1'b1);

        // Second strobe lands in ACC and must be dropped.
        set_ch(1234, 0, 0, 0, 8, 8, 8, 8, 4'b0000, 1'b0);
        sb.push_back({1'b0, 16'd1234});
        strobe();
        tick();
        set_ch(546, 0, 0, 0, 8, 8, 8, 8, 4'b0000, 1'b0);
        ce_sample = 1'b1;
        tick();
        ce_sample = 1'b0;
        chk("ovr_pulse", 32'(overrun), 32'd1);
        tick();
        chk("ovr_end", 32'(overrun), 32'd0);
        collect("ovr_first", 2);
        count_valid("ovr_single", 10, 0);
        run_mix("ovr_next", 16'd546, 1'b0);

        set_ch(2000, 0, 0, 0, 8, 8, 8, 8, 4'b0000, 1'b0);
        sb.push_back({1'b0, 16'd2000});
        strobe();
        tick();
        set_ch(-5000, 7000, 0, 0, 15, 15, 8, 8, 4'b0000, 1'b0);
        collect("snapshot", 4);

        for (int i = 0; i < 3; i++) begin
            for (int k = 0; k < 4; k++) begin
                logic [15:0] r;
                r       = 16'($urandom);
                cin[k]  = $signed(r);
                cvol[k] = $urandom_range(0, 15);
            end
            set_ch(cin[0], cin[1], cin[2], cin[3], cvol[0], cvol[1], cvol[2], cvol[3],
                   4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            begin
                logic [16:0] m;
                m = model();
                run_mix($sformatf("rand%0d", i), m[15:0], m[16]);
            end
        end

        set_ch(1000, 0, 0, 0, 8, 8, 8, 8, 4'b0000, 1'b0);
        strobe();
        tick();
        tick();
        reset = 1'b1;
        #1;
        chk("rstmid_busy", 32'(busy), 32'd0);
        chk("rstmid_audio", 32'(audio_out), 32'd0);
        chk("rstmid_valid", 32'(out_valid), 32'd0);
        tick();
        reset = 1'b0;
        count_valid("rstmid_novalid", 10, 0);
        chk("rstmid_audio_hold", 32'(audio_out), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
